// File: rtl/sata_oob_ctrl.sv
// Host-side SATA OOB and link-speed bring-up controller.
// Sequences COMRESET/COMWAKE, D10.2 and the ALIGN handshake, then hands the TX lanes to the link layer.
module sata_oob_ctrl #(
  parameter int unsigned RETRY_TIMEOUT  = 132000,
  parameter int unsigned ALIGN_TIMEOUT  = 8192,
  parameter int unsigned NONALIGN_COUNT = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_gtx_ready,
  input  logic        i_tx_comfinish,
  input  logic        i_rx_cominit_det,
  input  logic        i_rx_comwake_det,
  input  logic [31:0] i_rx_data,
  input  logic [3:0]  i_rx_charisk,
  output logic        o_tx_cominit,
  output logic        o_tx_comwake,
  output logic        o_tx_elecidle,
  output logic [31:0] o_tx_data,
  output logic [3:0]  o_tx_charisk,
  output logic        o_link_up,
  output logic [3:0]  o_oob_state
);

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_COMRESET     = 4'd1,
    ST_WAIT_CR_DONE = 4'd2,
    ST_WAIT_COMINIT = 4'd3,
    ST_WAIT_CI_CLR  = 4'd4,
    ST_COMWAKE      = 4'd5,
    ST_WAIT_CW_DONE = 4'd6,
    ST_WAIT_COMWAKE = 4'd7,
    ST_WAIT_CW_CLR  = 4'd8,
    ST_SEND_D102    = 4'd9,
    ST_SEND_ALIGN   = 4'd10,
    ST_LINK_UP      = 4'd11
  } state_t;

  localparam logic [31:0] PRIM_ALIGN = 32'h7B4A4ABC;
  localparam logic [31:0] PRIM_SYNC  = 32'hB5B5957C;
  localparam logic [31:0] PRIM_D102  = 32'h4A4A4A4A;
  localparam logic [23:0] RETRY_LAST = 24'(RETRY_TIMEOUT - 1);
  localparam logic [23:0] ALIGN_LAST = 24'(ALIGN_TIMEOUT - 1);
  localparam logic [1:0]  NA_LAST    = 2'(NONALIGN_COUNT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [23:0] r_timer;
  logic [1:0]  r_na_cnt;

  logic        r_tx_cominit;
  logic        r_tx_comwake;
  logic        r_tx_elecidle;
  logic [31:0] r_tx_data;
  logic [3:0]  r_tx_charisk;
  logic        r_link_up;

  logic        w_rx_align;
  logic        w_rx_nonalign;
  logic        w_retry_to;
  logic        w_align_to;
  logic        w_tx_cominit;
  logic        w_tx_comwake;
  logic        w_tx_elecidle;
  logic [31:0] w_tx_data;
  logic [3:0]  w_tx_charisk;
  logic        w_link_up;

  assign w_rx_align    = (i_rx_data == PRIM_ALIGN) && (i_rx_charisk == 4'b0001);
  assign w_rx_nonalign = i_rx_charisk[0] && (i_rx_data[7:0] == 8'h7C) && !w_rx_align;
  assign w_retry_to    = (r_timer == RETRY_LAST);
  assign w_align_to    = (r_timer == ALIGN_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:         if (i_gtx_ready) w_next = ST_COMRESET;
      ST_COMRESET:     w_next = ST_WAIT_CR_DONE;
      ST_WAIT_CR_DONE: if (i_tx_comfinish) w_next = ST_WAIT_COMINIT;
      ST_WAIT_COMINIT: begin
        if (i_rx_cominit_det)  w_next = ST_WAIT_CI_CLR;
        else if (w_retry_to)   w_next = ST_COMRESET;
      end
      ST_WAIT_CI_CLR:  if (!i_rx_cominit_det) w_next = ST_COMWAKE;
      ST_COMWAKE:      w_next = ST_WAIT_CW_DONE;
      ST_WAIT_CW_DONE: if (i_tx_comfinish) w_next = ST_WAIT_COMWAKE;
      ST_WAIT_COMWAKE: begin
        if (i_rx_comwake_det)  w_next = ST_WAIT_CW_CLR;
        else if (w_retry_to)   w_next = ST_COMRESET;
      end
      ST_WAIT_CW_CLR:  if (!i_rx_comwake_det) w_next = ST_SEND_D102;
      ST_SEND_D102: begin
        if (w_rx_align)        w_next = ST_SEND_ALIGN;
        else if (w_align_to)   w_next = ST_COMRESET;
      end
      ST_SEND_ALIGN: begin
        if (w_rx_nonalign && (r_na_cnt == NA_LAST)) w_next = ST_LINK_UP;
        else if (w_align_to)                        w_next = ST_COMRESET;
      end
      ST_LINK_UP:      if (i_rx_cominit_det) w_next = ST_COMRESET;
      default:         w_next = ST_IDLE;
    endcase
    // Losing the transceiver overrides every other transition.
    if ((r_state != ST_IDLE) && !i_gtx_ready) w_next = ST_IDLE;
  end

  // Outputs are decoded from the next state so the registers line up with r_state.
  always_comb begin
    w_tx_cominit  = (w_next == ST_COMRESET);
    w_tx_comwake  = (w_next == ST_COMWAKE);
    w_link_up     = (w_next == ST_LINK_UP);
    w_tx_elecidle = 1'b1;
    w_tx_data     = '0;
    w_tx_charisk  = '0;
    case (w_next)
      ST_SEND_D102: begin
        w_tx_elecidle = 1'b0;
        w_tx_data     = PRIM_D102;
      end
      ST_SEND_ALIGN: begin
        w_tx_elecidle = 1'b0;
        w_tx_data     = PRIM_ALIGN;
        w_tx_charisk  = 4'b0001;
      end
      ST_LINK_UP: begin
        w_tx_elecidle = 1'b0;
        w_tx_data     = PRIM_SYNC;
        w_tx_charisk  = 4'b0001;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_timer       <= '0;
      r_na_cnt      <= '0;
      r_tx_cominit  <= 1'b0;
      r_tx_comwake  <= 1'b0;
      r_tx_elecidle <= 1'b1;
      r_tx_data     <= '0;
      r_tx_charisk  <= '0;
      r_link_up     <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_timer       <= (w_next != r_state) ? '0 : r_timer + 24'd1;
      r_na_cnt      <= ((r_state == ST_SEND_ALIGN) && w_rx_nonalign) ? r_na_cnt + 2'd1 : '0;
      r_tx_cominit  <= w_tx_cominit;
      r_tx_comwake  <= w_tx_comwake;
      r_tx_elecidle <= w_tx_elecidle;
      r_tx_data     <= w_tx_data;
      r_tx_charisk  <= w_tx_charisk;
      r_link_up     <= w_link_up;
    end
  end

  assign o_tx_cominit  = r_tx_cominit;
  assign o_tx_comwake  = r_tx_comwake;
  assign o_tx_elecidle = r_tx_elecidle;
  assign o_tx_data     = r_tx_data;
  assign o_tx_charisk  = r_tx_charisk;
  assign o_link_up     = r_link_up;
  assign o_oob_state   = r_state;

endmodule

// File: tb/tb_sata_oob_ctrl.sv
// Scoreboard bench for sata_oob_ctrl: expected state transitions (with the dwell of the
// preceding state) are queued by the stimulus and checked by a negedge monitor.
module tb_sata_oob_ctrl;

  localparam int RETRY  = 1000;
  localparam int ALIGNT = 64;
  localparam int LAT    = 20;

  localparam logic [3:0] S_IDLE = 4'd0, S_COMRESET = 4'd1, S_WCR = 4'd2, S_WCI = 4'd3,
                         S_CI_CLR = 4'd4, S_COMWAKE = 4'd5, S_WCWD = 4'd6, S_WCW = 4'd7,
                         S_CW_CLR = 4'd8, S_D102 = 4'd9, S_ALIGN = 4'd10, S_LINK = 4'd11;

  localparam logic [31:0] ALIGN_P = 32'h7B4A4ABC;
  localparam logic [31:0] SYNC_P  = 32'hB5B5957C;

  logic        clk, rst, gtx_ready, tx_comfinish, rx_cominit_det, rx_comwake_det;
  logic [31:0] rx_data;
  logic [3:0]  rx_charisk;
  logic        tx_cominit, tx_comwake, tx_elecidle, link_up;
  logic [31:0] tx_data;
  logic [3:0]  tx_charisk, oob_state;
  logic [39:0] act_out;

  typedef struct {
    logic [3:0] st;
    int         dwell;
  } evt_t;

  evt_t exp_q[$];
  evt_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_evt_cyc = 0;
  int   mon_dw;
  logic [3:0] last_st = 4'hF;

  sata_oob_ctrl #(
    .RETRY_TIMEOUT (RETRY),
    .ALIGN_TIMEOUT (ALIGNT),
    .NONALIGN_COUNT(3)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_gtx_ready     (gtx_ready),
    .i_tx_comfinish  (tx_comfinish),
    .i_rx_cominit_det(rx_cominit_det),
    .i_rx_comwake_det(rx_comwake_det),
    .i_rx_data       (rx_data),
    .i_rx_charisk    (rx_charisk),
    .o_tx_cominit    (tx_cominit),
    .o_tx_comwake    (tx_comwake),
    .o_tx_elecidle   (tx_elecidle),
    .o_tx_data       (tx_data),
    .o_tx_charisk    (tx_charisk),
    .o_link_up       (link_up),
    .o_oob_state     (oob_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign act_out = {tx_cominit, tx_comwake, tx_elecidle, tx_data, tx_charisk, link_up};

  // Required output bundle for each state code.
  function automatic logic [39:0] exp_out(input logic [3:0] st);
    logic [31:0] d;
    logic [3:0]  k;
    d = '0;
    k = '0;
    case (st)
      4'd9:  d = 32'h4A4A4A4A;
      4'd10: begin d = 32'h7B4A4ABC; k = 4'b0001; end
      4'd11: begin d = 32'hB5B5957C; k = 4'b0001; end
      default: ;
    endcase
    return {st == 4'd1, st == 4'd5, st < 4'd9, d, k, st == 4'd11};
  endfunction

  task automatic push(input logic [3:0] st, input int dwell);
    evt_t e;
    e.st    = st;
    e.dwell = dwell;
    exp_q.push_back(e);
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic wait_state(input logic [3:0] st, input int max_cyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((oob_state !== st) && (n < max_cyc));
    if (oob_state !== st) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_state timeout: state=%0d required=%0d after %0d cycles", oob_state, st, n);
      finish_test();
    end
  endtask

  task automatic check_reset(input string name);
    n_checks++;
    if ({act_out, oob_state} !== {exp_out(S_IDLE), 4'd0}) begin
      n_fail++;
      $display("FAIL %s: outputs=%h state=%0d required=%h state=0", name, act_out, oob_state, exp_out(S_IDLE));
    end
  endtask

  task automatic set_rx(input logic [31:0] d, input logic [3:0] k);
    rx_data    = d;
    rx_charisk = k;
  endtask

  // Device handshake from the first WAIT_COMINIT cycle up to the first SEND_D102 cycle.
  task automatic oob_to_d102(input int det);
    push(S_CI_CLR, det);
    push(S_COMWAKE, 4);
    push(S_WCWD, 1);
    push(S_WCW, LAT + 1);
    push(S_CW_CLR, det);
    push(S_D102, 4);
    repeat (det - 1) @(negedge clk);
    rx_cominit_det = 1'b1;
    repeat (4) @(negedge clk);
    rx_cominit_det = 1'b0;
    wait_state(S_WCW, 200);
    repeat (det - 1) @(negedge clk);
    rx_comwake_det = 1'b1;
    repeat (4) @(negedge clk);
    rx_comwake_det = 1'b0;
    wait_state(S_D102, 50);
  endtask

  // Transceiver model: COMINIT/COMWAKE burst completes LAT idle cycles after the request.
  initial begin
    tx_comfinish = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && (tx_cominit || tx_comwake)) begin
        repeat (LAT + 1) @(negedge clk);
        tx_comfinish = 1'b1;
        @(negedge clk);
        tx_comfinish = 1'b0;
      end
    end
  end

  // Monitor: per-cycle output/state consistency, plus scoreboard pop on every state change.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      last_st = 4'hF;
    end else begin
      n_checks++;
      if (act_out !== exp_out(oob_state)) begin
        n_fail++;
        $display("FAIL outputs_vs_state cyc=%0d state=%0d got=%h required=%h", cyc, oob_state, act_out, exp_out(oob_state));
      end
      if (oob_state !== last_st) begin
        mon_dw       = cyc - last_evt_cyc;
        last_evt_cyc = cyc;
        last_st      = oob_state;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_transition cyc=%0d got state=%0d required none", cyc, oob_state);
        end else begin
          mon_e = exp_q.pop_front();
          if (oob_state !== mon_e.st) begin
            n_fail++;
            $display("FAIL transition_state cyc=%0d got=%0d required=%0d", cyc, oob_state, mon_e.st);
          end
          if (mon_e.dwell >= 0) begin
            n_checks++;
            if (mon_dw != mon_e.dwell) begin
              n_fail++;
              $display("FAIL dwell_before_state_%0d cyc=%0d got=%0d required=%0d", mon_e.st, cyc, mon_dw, mon_e.dwell);
            end
          end
        end
      end
    end
  end

  logic [31:0] seq_d [6];
  int          drain;

  initial begin
    seq_d = '{SYNC_P, SYNC_P, ALIGN_P, SYNC_P, SYNC_P, SYNC_P};
    rst = 1'b0;
    gtx_ready = 1'b0;
    rx_cominit_det = 1'b0;
    rx_comwake_det = 1'b0;
    set_rx('0, '0);

    // Reset, then nominal bring-up with 100-cycle device responses.
    push(S_IDLE, -1);
    push(S_COMRESET, 3);
    push(S_WCR, 1);
    push(S_WCI, LAT + 1);
    #2 rst = 1'b1;
    #1 check_reset("reset_values");
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    gtx_ready = 1'b1;
    wait_state(S_WCI, 100);
    oob_to_d102(100);
    push(S_ALIGN, 50);
    push(S_LINK, 3);
    repeat (49) @(negedge clk);
    set_rx(ALIGN_P, 4'b0001);
    @(negedge clk);
    set_rx(SYNC_P, 4'b0001);
    repeat (2) @(negedge clk);
    wait_state(S_LINK, 5);
    set_rx('0, '0);

    // Device-initiated COMINIT while link is up.
    push(S_COMRESET, 6);
    push(S_WCR, 1);
    push(S_WCI, LAT + 1);
    repeat (5) @(negedge clk);
    rx_cominit_det = 1'b1;
    @(negedge clk);
    rx_cominit_det = 1'b0;
    wait_state(S_WCI, 100);

    // No device: COMRESET retried every RETRY + LAT + 2 cycles.
    for (int i = 0; i < 2; i++) begin
      push(S_COMRESET, RETRY);
      push(S_WCR, 1);
      push(S_WCI, LAT + 1);
    end
    for (int i = 0; i < 2; i++) begin
      wait_state(S_COMRESET, RETRY + 10);
      wait_state(S_WCI, 100);
    end

    // ALIGN never returned: SEND_D102 lasts ALIGNT cycles.
    oob_to_d102(10);
    push(S_COMRESET, ALIGNT);
    push(S_WCR, 1);
    push(S_WCI, LAT + 1);
    wait_state(S_COMRESET, ALIGNT + 10);
    wait_state(S_WCI, 100);

    // ALIGN on the timeout cycle wins; non-ALIGN count restarted by an ALIGN.
    oob_to_d102(10);
    push(S_ALIGN, ALIGNT);
    push(S_LINK, 6);
    repeat (ALIGNT - 1) @(negedge clk);
    set_rx(ALIGN_P, 4'b0001);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      set_rx(seq_d[i], 4'b0001);
    end
    wait_state(S_LINK, 5);
    set_rx('0, '0);
    push(S_COMRESET, 3);
    push(S_WCR, 1);
    push(S_WCI, LAT + 1);
    repeat (2) @(negedge clk);
    rx_cominit_det = 1'b1;
    @(negedge clk);
    rx_cominit_det = 1'b0;
    wait_state(S_WCI, 100);

    // Asynchronous reset in SEND_ALIGN.
    oob_to_d102(10);
    push(S_ALIGN, 1);
    set_rx(ALIGN_P, 4'b0001);
    wait_state(S_ALIGN, 5);
    repeat (5) @(negedge clk);
    push(S_IDLE, -1);
    push(S_COMRESET, 1);
    push(S_WCR, 1);
    push(S_WCI, LAT + 1);
    #2 rst = 1'b1;
    #1 check_reset("async_reset_mid_align");
    set_rx('0, '0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    wait_state(S_WCI, 100);

    // gtx_ready loss returns to IDLE.
    push(S_IDLE, 11);
    repeat (10) @(negedge clk);
    gtx_ready = 1'b0;
    wait_state(S_IDLE, 5);

    drain = 0;
    while ((exp_q.size() != 0) && (drain < 20)) begin
      @(negedge clk);
      drain++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected transitions left, required 0", exp_q.size());
    end
    repeat (5) @(negedge clk);
    finish_test();
  end

endmodule
